// File: rtl/mc_control_fsm.sv
// Multi-cycle sequencing controller for the MIPS datapath (FETCH/DECODE/EXEC/MEM/WB).
// Define MC_CTRL_PERF_EN to add the cyc_cnt / inst_cnt performance counters.
module mc_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  fun,
    input  logic        zero,
    input  logic        dm_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npc_sel,
    output logic [1:0]  regdst,
    output logic [1:0]  wd_sel,
    output logic        alusrc,
    output logic [2:0]  aluop,
    output logic        ext_sel,
    output logic        rf_we,
    output logic        dm_req,
    output logic        dm_we,
    output logic        illegal,
    output logic        ill_flag,
    output logic        mem_err,
    output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] inst_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        EXEC   = 3'b010,
        MEM    = 3'b011,
        WB     = 3'b100
    } state_t;

    typedef enum logic [3:0] {
        I_ILL, I_NOP, I_ADDU, I_SUBU, I_AND, I_OR, I_JR,
        I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL
    } inst_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_OR  = 3'b010,
        ALU_AND = 3'b011,
        ALU_LUI = 3'b100
    } alu_t;

    state_t     state_q, state_d;
    inst_t      inst;
    logic [3:0] wait_cnt;
    logic       mem_timeout;

    // The counter is compared one below the limit so the limit-th MEM cycle is the last one.
    assign mem_timeout = (wait_cnt == 4'(MEM_TIMEOUT - 1));
    assign state       = state_q;

    always_comb begin
        inst = I_ILL;
        case (op)
            6'b000000: begin
                case (fun)
                    6'b000000: inst = I_NOP;
                    6'b100001: inst = I_ADDU;
                    6'b100011: inst = I_SUBU;
                    6'b100100: inst = I_AND;
                    6'b100101: inst = I_OR;
                    6'b001000: inst = I_JR;
                    default:   inst = I_ILL;
                endcase
            end
            6'b001101: inst = I_ORI;
            6'b001111: inst = I_LUI;
            6'b100011: inst = I_LW;
            6'b101011: inst = I_SW;
            6'b000100: inst = I_BEQ;
            6'b000010: inst = I_J;
            6'b000011: inst = I_JAL;
            default:   inst = I_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            wait_cnt <= '0;
            ill_flag <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= (state_q == MEM && state_d == MEM) ? wait_cnt + 4'd1 : '0;
            ill_flag <= ill_flag | illegal;
            mem_err  <= mem_err | (state_q == MEM && !dm_ack && mem_timeout);
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: state_d = (inst == I_ILL || inst == I_NOP) ? FETCH : EXEC;
            EXEC: begin
                case (inst)
                    I_ADDU, I_SUBU, I_AND, I_OR, I_ORI, I_LUI: state_d = WB;
                    I_LW, I_SW:                                 state_d = MEM;
                    default:                                    state_d = FETCH;
                endcase
            end
            MEM: begin
                if (dm_ack)
                    state_d = (inst == I_LW) ? WB : FETCH;
                else if (mem_timeout)
                    state_d = FETCH;
                else
                    state_d = MEM;
            end
            WB:      state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        npc_sel = 2'b00;
        regdst  = 2'b00;
        wd_sel  = 2'b00;
        alusrc  = 1'b0;
        aluop   = ALU_ADD;
        ext_sel = 1'b0;
        rf_we   = 1'b0;
        dm_req  = 1'b0;
        dm_we   = 1'b0;
        illegal = 1'b0;
        if (reset) begin
            case (state_q)
                FETCH: ir_we = 1'b1;
                DECODE: begin
                    if (inst == I_ILL || inst == I_NOP) pc_we = 1'b1;
                    illegal = (inst == I_ILL);
                end
                EXEC: begin
                    case (inst)
                        I_ADDU: aluop = ALU_ADD;
                        I_SUBU: aluop = ALU_SUB;
                        I_AND:  aluop = ALU_AND;
                        I_OR:   aluop = ALU_OR;
                        I_ORI: begin
                            aluop  = ALU_OR;
                            alusrc = 1'b1;
                        end
                        I_LUI: begin
                            aluop  = ALU_LUI;
                            alusrc = 1'b1;
                        end
                        I_LW, I_SW: begin
                            aluop   = ALU_ADD;
                            alusrc  = 1'b1;
                            ext_sel = 1'b1;
                        end
                        I_BEQ: begin
                            aluop   = ALU_SUB;
                            pc_we   = 1'b1;
                            npc_sel = zero ? 2'b01 : 2'b00;
                        end
                        I_J: begin
                            pc_we   = 1'b1;
                            npc_sel = 2'b10;
                        end
                        I_JAL: begin
                            pc_we   = 1'b1;
                            npc_sel = 2'b10;
                            rf_we   = 1'b1;
                            regdst  = 2'b10;
                            wd_sel  = 2'b10;
                        end
                        I_JR: begin
                            pc_we   = 1'b1;
                            npc_sel = 2'b11;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    // Address generation controls held from EXEC so the address stays stable.
                    aluop   = ALU_ADD;
                    alusrc  = 1'b1;
                    ext_sel = 1'b1;
                    dm_req  = 1'b1;
                    dm_we   = (inst == I_SW);
                    pc_we   = dm_ack ? (inst == I_SW) : mem_timeout;
                end
                WB: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    case (inst)
                        I_LW: begin
                            regdst = 2'b00;
                            wd_sel = 2'b01;
                        end
                        I_ORI, I_LUI: regdst = 2'b00;
                        default:      regdst = 2'b01;
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            cyc_cnt  <= cyc_cnt + 32'd1;
            inst_cnt <= inst_cnt + {31'd0, pc_we};
        end
    end
`endif

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle sequencing controller for the MIPS core datapath: PC, instruction register, register file, ALU, sign/zero extender and data memory. It replaces single-cycle decoding with a FETCH/DECODE/EXEC/MEM/WB state machine. It drives every mux select and write enable, one phase per clock. It waits on a data-memory acknowledge so slower memories can be attached.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum cycles spent in MEM waiting for `dm_ack` before the access is abandoned.

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `op`, input, 6: IR[31:26]; valid from DECODE onward.
- `fun`, input, 6: IR[5:0].
- `zero`, input, 1: ALU zero flag; sampled in EXEC.
- `dm_ack`, input, 1: data memory has completed the current access.
- `ir_we`, output, 1: load the IR from instruction memory.
- `pc_we`, output, 1: load the PC from the next-PC mux.
- `npc_sel`, output, 2: next-PC source. 00 = pc+4, 01 = pc+4+(sext(imm)<<2), 10 = {pc[31:28], instr_index, 00}, 11 = rs.
- `regdst`, output, 2: write-register select. 00 = rt, 01 = rd, 10 = $31.
- `wd_sel`, output, 2: write-data select. 00 = ALU result, 01 = DM data, 10 = pc+4.
- `alusrc`, output, 1: 1 = extended immediate, 0 = rt.
- `aluop`, output, 3: 000 ADD, 001 SUB, 010 OR, 011 AND, 100 LUI (B<<16).
- `ext_sel`, output, 1: 1 = sign-extend, 0 = zero-extend.
- `rf_we`, output, 1: register file write enable.
- `dm_req`, output, 1: data memory access request.
- `dm_we`, output, 1: data memory write; qualified by `dm_req`.
- `illegal`, output, 1: one-cycle pulse on an undecodable instruction.
- `ill_flag`, output, 1: sticky illegal-instruction flag.
- `mem_err`, output, 1: sticky MEM timeout flag.
- `state`, output, 3: current state, for debug.

## Operation
- Supported instructions:
  - R-type (op=0): addu (fun 100001), subu (100011), and (100100), or (100101), jr (001000), and the all-zero word treated as nop.
  - I-type and J-type: ori (001101), lui (001111), lw (100011), sw (101011), beq (000100), j (000010), jal (000011).
- State encoding: FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100.
- FETCH: `ir_we`=1, then go to DECODE.
- DECODE: classify the instruction.
  - Illegal: `illegal`=1, `ill_flag` set, `pc_we`=1 with `npc_sel`=00, go to FETCH.
  - nop: `pc_we`=1 with `npc_sel`=00, go to FETCH.
  - All others: go to EXEC.
- EXEC: `aluop`, `alusrc` and `ext_sel` are driven per instruction.
  - addu/subu/and/or: ALU on rs and rt, go to WB.
  - ori: OR with the zero-extended immediate, go to WB.
  - lui: LUI with the zero-extended immediate, go to WB.
  - lw/sw: ADD with the sign-extended immediate, go to MEM.
  - beq: SUB, `pc_we`=1, `npc_sel`=01 if `zero` else 00, go to FETCH.
  - j: `pc_we`=1, `npc_sel`=10, go to FETCH.
  - jal: additionally `rf_we`=1, `regdst`=10, `wd_sel`=10.
  - jr: `pc_we`=1, `npc_sel`=11, go to FETCH.
- MEM: `dm_req`=1, `dm_we`=1 for sw. The ALU controls from EXEC are held so the address stays stable.
  - On `dm_ack`: lw goes to WB; sw asserts `pc_we` with `npc_sel`=00 and goes to FETCH.
  - A 4-bit wait counter increments each MEM cycle without `dm_ack`.
  - When the counter reaches `MEM_TIMEOUT` without `dm_ack`: set `mem_err`, assert `pc_we` with `npc_sel`=00, go to FETCH. For lw there is no register write.
- WB: `rf_we`=1, `pc_we`=1 with `npc_sel`=00, go to FETCH.
  - R-type: `regdst`=01, `wd_sel`=00.
  - ori/lui: `regdst`=00, `wd_sel`=00.
  - lw: `regdst`=00, `wd_sel`=01.
- Every output not listed for a state is 0. Writes to $0 are left to the register file.
- `dm_ack` outside MEM is ignored. `dm_ack` in the same cycle the counter reaches `MEM_TIMEOUT` counts as success.

## Timing
- While `reset`=0: state=FETCH, wait counter=0, `ill_flag`=0, `mem_err`=0, and every output=0, including strobes gated low. FETCH is therefore active in the first edge after release.
- Outputs are combinational from state and `op`/`fun`, so a strobe is valid for the whole cycle and takes effect at the closing edge.
- Cycles per instruction:
  - nop and illegal: 2.
  - beq, j, jal, jr: 3.
  - ALU ops: 4.
  - sw: 3 + MEM cycles, minimum 4.
  - lw: 4 + MEM cycles, minimum 5.
- `pc_we` is asserted exactly once per instruction, in its final state.
- Reset asserted mid-instruction aborts it immediately. No partial `rf_we` or `dm_we` is issued after the reset edge.

## Configuration
- Macro `MC_CTRL_PERF_EN`.
- Defined: adds outputs `cyc_cnt` [31:0] and `inst_cnt` [31:0], both reset to 0.
  - `cyc_cnt` increments every cycle.
  - `inst_cnt` increments on every `pc_we`.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- addu $3,$1,$2 (op 0, fun 100001) -> states 000,001,010,100. In WB: `rf_we`=1, `regdst`=01, `pc_we`=1, `npc_sel`=00. 4 cycles total.
- lw with `dm_ack` raised on the 3rd MEM cycle -> `dm_req` high for 3 cycles, then WB with `wd_sel`=01. 7 cycles total.
- beq with `zero`=1, then beq with `zero`=0 -> EXEC gives `npc_sel`=01, then `npc_sel`=00. Each takes 3 cycles; no `rf_we`.
- jal -> EXEC gives `rf_we`=1, `regdst`=10, `wd_sel`=10, `npc_sel`=10. op=111111 -> `illegal` pulses once, `ill_flag` stays 1, next state FETCH.
- sw with `dm_ack` held 0 -> `mem_err`=1 after 15 MEM cycles, `pc_we` with `npc_sel`=00, `dm_we` never seen outside MEM.
- Reset pulled low during the lw MEM state -> all outputs 0 in the same cycle, state=000. After release, FETCH with `ir_we`=1. With `MC_CTRL_PERF_EN` defined, `cyc_cnt`=0 and `inst_cnt`=0.
